seg_encoder_seq: RTL and testbench
==================================

Name: seg_encoder_seq

Overview:
Sequential, parametrised binary-to-seven-segment display encoder for the timer display path. It accepts NCH binary channels (for example minutes and seconds) and converts each channel serially with a shift-add-3 (double-dabble) engine into DIG_PER_CH active-low seven-segment digits. It supports a count-up mode and a countdown mode (display = limit − value), with a valid/ready handshake. All segment outputs are committed atomically, so the display never shows a partially converted frame.

Parameters:
NCH, 2, number of binary channels (fields) shown on the display
IN_W, 8, width of each channel's binary input and countdown limit
DIG_PER_CH, 2, number of decimal digits displayed per channel

Ports:
clk  in  1  system clock; all logic is rising-edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  request to convert value/mode/down_max
in_ready  out  1  high when idle (equals !busy); a transfer occurs when in_valid && in_ready
mode  in  1  0 = count-up (display value), 1 = countdown (display down_max − value)
value  in  NCH*IN_W  packed channel values; channel 0 occupies the LSBs
down_max  in  NCH*IN_W  packed per-channel countdown limits
seg  out  NCH*DIG_PER_CH*7  active-low segments {g,f,e,d,c,b,a}; digit 0 = least significant digit of channel 0
done  out  1  one-cycle pulse on the edge that updates seg
busy  out  1  high while a conversion is in progress
ovf  out  NCH  per-channel out-of-range flag; updated together with seg

Behaviour:
- Digit codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, dash=0111111, blank=1111111.
- Reset (synchronous, takes priority over everything): FSM goes to IDLE; every seg digit = code 0; done=0; busy=0; ovf=0. A reset during a conversion aborts it, and done is never asserted for that conversion.
- Transfer: in IDLE, in_valid=1 on a rising edge captures mode, value and down_max into internal registers. Input changes after the capture edge have no effect.
- in_valid while busy: ignored. There is no queue and no error is flagged.
- FSM states: IDLE → LOAD → SHIFT → STORE → (LOAD for the next channel | COMMIT) → IDLE.
- LOAD (1 cycle):
  - Compute the display value for channel k (starting at k=0).
  - mode 0: v = value[k].
  - mode 1, all captured channel values zero: v = 0 (terminal 00..00 display).
  - mode 1, otherwise: v = down_max[k] − value[k]. If value[k] > down_max[k], mark ovf[k].
  - Clear the BCD register, which holds ceil(IN_W/3)+1 digits.
- SHIFT (exactly IN_W cycles): before each left shift of {bcd, v}, add 3 to every BCD digit ≥ 5.
- STORE (1 cycle): if any BCD digit at index ≥ DIG_PER_CH is nonzero, mark ovf[k]. If ovf[k] is set, all digits of channel k become dash; otherwise they take the decimal codes. Results go to a shadow register.
- COMMIT (1 cycle): copy the shadow register to seg and the pending flags to ovf; pulse done=1; return to IDLE.
- Latency: seg and done update on edge NCH*(IN_W+2)+1 after the capture edge, which is 21 for the defaults. busy is high from the capture edge until that edge, so it is low in the cycle after done. A back-to-back transfer is possible in the cycle done is high.
- Between commits, seg and ovf hold their previous values.
- Arithmetic: the subtraction is IN_W bits wide and unsigned. All BCD digits are 4 bits.

Optional Feature:
Macro SEG_LZ_BLANK_EN. When defined: during STORE of channel NCH−1 only (the most significant field), leading zero digits are replaced with blank (1111111). The least significant digit of that channel is never blanked, and dash digits are unaffected. When not defined: leading zeros are displayed as 0.

Test Plan:
- Reset, then mode=0, value ch1=12, ch0=34 → done exactly 21 cycles after capture; seg digits 1,2,3,4; ovf=00; busy low the cycle after done.
- mode=1, down_max ch1=3, ch0=59; value ch1=1, ch0=0 → display 02:59. Then value ch1=3, ch0=59 → 00:00. Then all values 0 → 00:00, ovf=00.
- mode=0, ch0=150, ch1=7 → ch0 shows dash,dash; ch1 shows 0,7; ovf=01. Then mode=1, down_max ch0=10, value ch0=20 → ovf[0]=1 with dashes.
- Drive in_valid continuously with changing value during a conversion → exactly one done per 21 cycles, and each result matches the value captured at its capture edge.
- Assert reset at cycle 10 of a conversion → all digits read 0, no done pulse; a fresh request afterwards completes normally.
- With SEG_LZ_BLANK_EN: ch1=5, ch0=7 → ch1 high digit blank, ch1 low digit 5, ch0 shows 0,7. Without the macro → 0,5,0,7.

Source files
------------

// File: rtl/seg_encoder_seq.sv
// Purpose : serial double-dabble binary-to-7-segment encoder, NCH channels, count-up or countdown display.
// Latency : seg/ovf/done update NCH*(IN_W+2)+1 edges after the capture edge (21 for the defaults).
// Backpressure: in_ready = !busy; in_valid while busy is ignored, with no queue and no error flag.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  request handshake; a transfer occurs on in_valid && in_ready
//   mode            0 = show value, 1 = show down_max - value
//   value, down_max packed per-channel inputs, channel 0 in the LSBs
//   seg             active-low {g,f,e,d,c,b,a} per digit; digit 0 = LSD of channel 0
//   done            one-cycle pulse after the edge that updates seg
//   busy            conversion in progress
//   ovf             per-channel out-of-range flags, updated together with seg
// Build option: define SEG_LZ_BLANK_EN to blank leading zeros of the most significant channel.
module seg_encoder_seq #(
   parameter int NCH        = 2,
   parameter int IN_W       = 8,
   parameter int DIG_PER_CH = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         mode,
   input  logic [NCH*IN_W-1:0]          value,
   input  logic [NCH*IN_W-1:0]          down_max,
   output logic [NCH*DIG_PER_CH*7-1:0]  seg,
   output logic                         done,
   output logic                         busy,
   output logic [NCH-1:0]               ovf
);

   // BCD register holds enough digits for any IN_W-bit value plus one spare.
   localparam int ND   = (IN_W + 2) / 3 + 1;
   localparam int BW   = ND * 4;
   localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int SW   = $clog2(IN_W + 1);
   localparam int CHW  = DIG_PER_CH * 7;
   localparam int SEGW = NCH * CHW;

   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_ZERO  = 7'b1000000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_STORE,
      S_COMMIT
   } state_t;

   state_t state, state_nxt;

   logic                  mode_q;
   logic [NCH*IN_W-1:0]   value_q;
   logic [NCH*IN_W-1:0]   dmax_q;
   logic [CW-1:0]         ch;
   logic [SW-1:0]         sh_cnt;
   logic [BW+IN_W-1:0]    dd;        // {bcd, binary} shift register
   logic [SEGW-1:0]       shadow;
   logic [NCH-1:0]        ovf_pend;

   logic [IN_W-1:0]       ch_val;
   logic [IN_W-1:0]       ch_max;
   logic [IN_W-1:0]       load_v;
   logic                  load_ovf;
   logic [BW-1:0]         bcd;
   logic                  hi_nz;
   logic                  ovf_k;
   logic [CHW-1:0]        store_codes;
   logic                  last_ch;

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      logic [6:0] c;
      case (d)
         4'd0:    c = 7'b1000000;
         4'd1:    c = 7'b1111001;
         4'd2:    c = 7'b0100100;
         4'd3:    c = 7'b0110000;
         4'd4:    c = 7'b0011001;
         4'd5:    c = 7'b0010010;
         4'd6:    c = 7'b0000010;
         4'd7:    c = 7'b1111000;
         4'd8:    c = 7'b0000000;
         4'd9:    c = 7'b0010000;
         default: c = SEG_BLANK;
      endcase
      return c;
   endfunction

   // Add-3 correction applied to every BCD digit before each left shift.
   function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
      logic [BW-1:0] r;
      r = b;
      for (int i = 0; i < ND; i++) begin
         if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
      end
      return r;
   endfunction

   assign busy     = (state != S_IDLE);
   assign in_ready = !busy;
   assign bcd      = dd[IN_W +: BW];
   assign last_ch  = (ch == CW'(NCH - 1));

   // Display value for the current channel.
   always_comb begin
      ch_val   = value_q[int'(ch)*IN_W +: IN_W];
      ch_max   = dmax_q[int'(ch)*IN_W +: IN_W];
      load_v   = '0;
      load_ovf = 1'b0;
      if (!mode_q) begin
         load_v = ch_val;
      end else if (value_q == '0) begin
         // Countdown finished: show all zeros regardless of the limits.
         load_v = '0;
      end else begin
         load_v   = ch_max - ch_val;
         load_ovf = (ch_val > ch_max);
      end
   end

   // Digit codes for the channel being stored.
   always_comb begin
      logic [3:0] d;
      logic [6:0] code;
`ifdef SEG_LZ_BLANK_EN
      logic       lead;
      lead = 1'b1;
`endif
      hi_nz       = 1'b0;
      store_codes = '0;
      d           = '0;
      code        = SEG_ZERO;
      for (int i = DIG_PER_CH; i < ND; i++) begin
         if (bcd[i*4 +: 4] != 4'd0) hi_nz = 1'b1;
      end
      ovf_k = ovf_pend[ch] | hi_nz;
      for (int j = DIG_PER_CH - 1; j >= 0; j--) begin
         d    = bcd[j*4 +: 4];
         code = seg_code(d);
`ifdef SEG_LZ_BLANK_EN
         // Only the most significant field is blanked, and never its last digit.
         if (last_ch && lead && (d == 4'd0) && (j != 0)) code = SEG_BLANK;
         if (d != 4'd0) lead = 1'b0;
`endif
         if (ovf_k) code = SEG_DASH;
         store_codes[j*7 +: 7] = code;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (in_valid) state_nxt = S_LOAD;
         S_LOAD:   state_nxt = S_SHIFT;
         S_SHIFT:  if (sh_cnt == SW'(IN_W - 1)) state_nxt = S_STORE;
         S_STORE:  state_nxt = last_ch ? S_COMMIT : S_LOAD;
         S_COMMIT: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q   <= 1'b0;
         value_q  <= '0;
         dmax_q   <= '0;
         ch       <= '0;
         sh_cnt   <= '0;
         dd       <= '0;
         shadow   <= {(NCH*DIG_PER_CH){SEG_ZERO}};
         ovf_pend <= '0;
         seg      <= {(NCH*DIG_PER_CH){SEG_ZERO}};
         ovf      <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  mode_q   <= mode;
                  value_q  <= value;
                  dmax_q   <= down_max;
                  ch       <= '0;
                  ovf_pend <= '0;
               end
            end
            S_LOAD: begin
               dd           <= {{BW{1'b0}}, load_v};
               sh_cnt       <= '0;
               ovf_pend[ch] <= load_ovf;
            end
            S_SHIFT: begin
               dd     <= {add3(bcd), dd[IN_W-1:0]} << 1;
               sh_cnt <= sh_cnt + SW'(1);
            end
            S_STORE: begin
               shadow[int'(ch)*CHW +: CHW] <= store_codes;
               ovf_pend[ch]                <= ovf_k;
               if (!last_ch) ch <= ch + CW'(1);
            end
            S_COMMIT: begin
               seg  <= shadow;
               ovf  <= ovf_pend;
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seg_encoder_seq.sv
// Purpose : scoreboard bench for seg_encoder_seq against an arithmetic display model.
// Latency : every done is checked to arrive 21 edges after its capture edge.
// Backpressure: requests wait for in_ready; a continuous in_valid burst exercises ignored requests.
module tb_seg_encoder_seq;

   localparam int NCH  = 2;
   localparam int IN_W = 8;
   localparam int DPC  = 2;
   localparam int SEGW = NCH * DPC * 7;
   localparam int LAT  = NCH * (IN_W + 2) + 1;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 in_valid;
   logic                 in_ready;
   logic                 mode;
   logic [NCH*IN_W-1:0]  value;
   logic [NCH*IN_W-1:0]  down_max;
   logic [SEGW-1:0]      seg;
   logic                 done;
   logic                 busy;
   logic [NCH-1:0]       ovf;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;

   logic [SEGW-1:0] q_seg[$];
   logic [NCH-1:0]  q_ovf[$];
   int              q_cap[$];

   seg_encoder_seq #(.NCH(NCH), .IN_W(IN_W), .DIG_PER_CH(DPC)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .mode     (mode),
      .value    (value),
      .down_max (down_max),
      .seg      (seg),
      .done     (done),
      .busy     (busy),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [6:0] dig_code(input int d);
      logic [6:0] t [10];
      t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
      return t[d];
   endfunction

   // Display model from the decimal rules: pick the number, range-check it, print its digits.
   task automatic model(input logic m, input logic [NCH*IN_W-1:0] val, input logic [NCH*IN_W-1:0] dm,
                        output logic [SEGW-1:0] s, output logic [NCH-1:0] o);
      int vk, dk, v, pw, p;
      logic [6:0] code;
      s = '0;
      o = '0;
      pw = 10 ** DPC;
      for (int k = 0; k < NCH; k++) begin
         vk = int'(val[k*IN_W +: IN_W]);
         dk = int'(dm[k*IN_W +: IN_W]);
         v = 0;
         if (!m) v = vk;
         else if (val == '0) v = 0;
         else if (vk > dk) o[k] = 1'b1;
         else v = dk - vk;
         if (v >= pw) o[k] = 1'b1;
         for (int j = 0; j < DPC; j++) begin
            p = 10 ** j;
            code = dig_code((v / p) % 10);
`ifdef SEG_LZ_BLANK_EN
            if (k == NCH - 1 && j != 0 && v < p) code = 7'b1111111;
`endif
            if (o[k]) code = 7'b0111111;
            s[(k*DPC + j)*7 +: 7] = code;
         end
      end
   endtask

   task automatic push_exp(input logic m, input logic [NCH*IN_W-1:0] v, input logic [NCH*IN_W-1:0] d);
      logic [SEGW-1:0] s;
      logic [NCH-1:0]  o;
      model(m, v, d, s, o);
      q_seg.push_back(s);
      q_ovf.push_back(o);
      q_cap.push_back(cyc + 1);
   endtask

   // Monitor: every done must match the oldest outstanding request.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cnt++;
         if (q_seg.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
         end else begin
            logic [SEGW-1:0] es;
            logic [NCH-1:0]  eo;
            int              ec;
            es = q_seg.pop_front();
            eo = q_ovf.pop_front();
            ec = q_cap.pop_front();
            chk("seg", 64'(seg), 64'(es));
            chk("ovf", 64'(ovf), 64'(eo));
            chk("latency", 64'(cyc - ec), 64'(LAT));
            chk("busy_at_done", 64'(busy), 64'd0);
         end
      end
   end

   // Called at a negedge; waits for in_ready, presents one request for one cycle.
   task automatic issue(input logic m, input logic [NCH*IN_W-1:0] v, input logic [NCH*IN_W-1:0] d);
      int t;
      t = 0;
      while (in_ready !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (in_ready !== 1'b1) begin
         chk("ready_timeout", 64'(in_ready), 64'd1);
      end else begin
         mode = m;
         value = v;
         down_max = d;
         in_valid = 1'b1;
         push_exp(m, v, d);
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (q_seg.size() != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("drain_pending", 64'(q_seg.size()), 64'd0);
      @(negedge clk);
   endtask

   initial begin
      int n0, pushed;
      logic [7:0] a, b;
      reset = 1'b1;
      in_valid = 1'b0;
      mode = 1'b0;
      value = '0;
      down_max = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("reset_seg", 64'(seg), 64'({4{7'b1000000}}));
      chk("reset_ovf", 64'(ovf), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_ready", 64'(in_ready), 64'd1);

      // Count-up 12:34
      issue(1'b0, {8'd12, 8'd34}, '0);
      drain();
      chk("seg_1234", 64'(seg), 64'({7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}));

      // Countdown cases
      issue(1'b1, {8'd1, 8'd0}, {8'd3, 8'd59});
      issue(1'b1, {8'd3, 8'd59}, {8'd3, 8'd59});
      issue(1'b1, '0, {8'd3, 8'd59});
      // Range overflow in count-up and countdown
      issue(1'b0, {8'd7, 8'd150}, '0);
      issue(1'b1, {8'd0, 8'd20}, {8'd0, 8'd10});
      // Leading-zero field
      issue(1'b0, {8'd5, 8'd7}, '0);
      // Boundaries
      issue(1'b0, {8'd99, 8'd100}, '0);
      issue(1'b0, {8'd255, 8'd0}, '0);
      drain();

      // Continuous in_valid with a new value every cycle
      n0 = done_cnt;
      pushed = 0;
      for (int i = 0; i < 110; i++) begin
         mode = 1'($urandom_range(0, 1));
         value = 16'($urandom);
         down_max = 16'($urandom);
         in_valid = 1'b1;
         if (in_ready === 1'b1) begin
            push_exp(mode, value, down_max);
            pushed++;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      drain();
      chk("burst_done_count", 64'(done_cnt - n0), 64'(pushed));

      // Reset in the middle of a conversion
      issue(1'b0, {8'd42, 8'd17}, '0);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      q_seg.delete();
      q_ovf.delete();
      q_cap.delete();
      n0 = done_cnt;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_seg", 64'(seg), 64'({4{7'b1000000}}));
      chk("abort_ovf", 64'(ovf), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      repeat (30) @(negedge clk);
      chk("abort_no_done", 64'(done_cnt - n0), 64'd0);
      issue(1'b0, {8'd8, 8'd9}, '0);
      drain();

      // Randomized traffic
      for (int i = 0; i < 40; i++) begin
         a = 8'($urandom_range(0, 120));
         b = 8'($urandom_range(0, 120));
         if ($urandom_range(0, 7) == 0) begin
            a = 8'd0;
            b = 8'd0;
         end
         issue(1'($urandom_range(0, 1)), {a, b},
               {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))});
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
